mdr_ctrl: RTL and testbench

MDR_CTRL -- requirements
Module: mdr_ctrl

---
 rtl/mdr_ctrl.sv | 107 ++++++++++
 tb/tb_mdr_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mdr_ctrl.sv
// Memory data register controller: loads the MDR from the M/S buses or from memory,
// and sequences single memory reads/writes with an acknowledge timeout.
module mdr_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] M_bus,
  input  logic [WIDTH-1:0] S_bus,
  input  logic             MMD,
  input  logic             SMD,
  input  logic             mem_rd_req,
  input  logic             mem_wr_req,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] MDR_out,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mdr;
  logic [CNT_W-1:0]   cnt;

  assign MDR_out   = mdr;
  assign mem_wdata = mdr;

  // State, MDR, wait counter and strobes all update together; strobes track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mdr    <= '0;
      cnt    <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case ({MMD, SMD})
            2'b10:   mdr <= M_bus;
            2'b01:   mdr <= S_bus;
            2'b11:   mdr <= M_bus | S_bus;
            default: mdr <= mdr;
          endcase
          cnt <= '0;
          if (mem_rd_req) begin
            state  <= RD_WAIT;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end else if (mem_wr_req) begin
            state  <= WR_WAIT;
            mem_wr <= 1'b1;
            busy   <= 1'b1;
          end
        end

        RD_WAIT, WR_WAIT: begin
          // cnt holds (wait cycle number - 1); the last legal ack cycle is TIMEOUT.
          if (mem_ack) begin
            if (state == RD_WAIT) mdr <= mem_rdata;
            state  <= IDLE;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state  <= ERR;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ERR: begin
          state <= IDLE;
          err   <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_ctrl.sv
// Bench for mdr_ctrl: a 16-bit/TIMEOUT=15 instance and an 8-bit/TIMEOUT=1 instance.
module tb_mdr_ctrl;

  logic        clk;
  logic        rst;

  logic [15:0] M_bus, S_bus, mem_rdata, mem_wdata, MDR_out;
  logic        MMD, SMD, mem_rd_req, mem_wr_req, mem_ack;
  logic        mem_rd, mem_wr, busy, err;

  logic [7:0]  b_M_bus, b_S_bus, b_mem_rdata, b_mem_wdata, b_MDR_out;
  logic        b_MMD, b_SMD, b_mem_rd_req, b_mem_wr_req, b_mem_ack;
  logic        b_mem_rd, b_mem_wr, b_busy, b_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  mdr_ctrl #(.WIDTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .M_bus(M_bus), .S_bus(S_bus), .MMD(MMD), .SMD(SMD),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .MDR_out(MDR_out), .busy(busy), .err(err)
  );

  mdr_ctrl #(.WIDTH(8), .TIMEOUT(1)) dut_b (
    .clk(clk), .rst(rst), .M_bus(b_M_bus), .S_bus(b_S_bus), .MMD(b_MMD), .SMD(b_SMD),
    .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req), .mem_rdata(b_mem_rdata),
    .mem_ack(b_mem_ack), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
    .MDR_out(b_MDR_out), .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required end before 500us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (MDR_out !== 16'h0000) begin errors++; $display("FAIL reset_mdr: got %h want 0000", MDR_out); end
    checks++; if (b_MDR_out !== 8'h00 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b: got mdr=%h busy=%b want 00/0", b_MDR_out, b_busy); end
  endtask

  task automatic test_bus_load();
    M_bus = 16'h1234; S_bus = 16'h00F0; MMD = 1'b1; SMD = 1'b1;
    exp_q.push_back(16'h12F4);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL load_or: got %h want %h", MDR_out, exp_v); end
    MMD = 1'b0; SMD = 1'b1;
    exp_q.push_back(16'h00F0);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL load_s: got %h want %h", MDR_out, exp_v); end
    MMD = 1'b0; SMD = 1'b0; M_bus = 16'hFFFF; S_bus = 16'hEEEE;
    exp_q.push_back(16'h00F0);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL load_hold: got %h want %h", MDR_out, exp_v); end
    checks++; if (mem_wdata !== exp_v) begin errors++; $display("FAIL wdata_follow: got %h want %h", mem_wdata, exp_v); end
    M_bus = 16'hC3C3; MMD = 1'b1;
    exp_q.push_back(16'hC3C3);
    tick();
    MMD = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL load_m: got %h want %h", MDR_out, exp_v); end
    // ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    exp_q.push_back(16'hC3C3);
    tick();
    mem_ack = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v || busy !== 1'b0) begin errors++; $display("FAIL idle_ack: got mdr=%h busy=%b want %h/0", MDR_out, busy, exp_v); end
  endtask

  task automatic test_read();
    int n;
    n = 0;
    mem_rd_req = 1'b1;
    exp_q.push_back(16'hBEEF);
    tick();
    mem_rd_req = 1'b0;
    checks++; if (busy !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL rd_enter: got busy=%b mem_wr=%b want 1/0", busy, mem_wr); end
    for (int i = 0; i < 40 && mem_rd; i++) begin
      n++;
      if (n == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
      mem_ack = 1'b0;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL rd_cycles: got %0d want 3", n); end
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL rd_data: got %h want %h", MDR_out, exp_v); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rd_done: got busy=%b err=%b want 0/0", busy, err); end
  endtask

  task automatic test_write_timeout();
    int n;
    n = 0;
    M_bus = 16'hA5A5; MMD = 1'b1;
    tick();
    MMD = 1'b0;
    mem_wr_req = 1'b1;
    exp_q.push_back(16'hA5A5);
    tick();
    mem_wr_req = 1'b0;
    for (int i = 0; i < 40 && mem_wr; i++) begin
      n++;
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_wait_flags: got err=%b busy=%b want 0/1", err, busy); end
      tick();
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL wr_cycles: got %0d want 15", n); end
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_err: got err=%b busy=%b want 1/1", err, busy); end
    tick();
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse: got err=%b busy=%b want 0/0", err, busy); end
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v || mem_wdata !== exp_v) begin errors++; $display("FAIL wr_mdr: got %h/%h want %h", MDR_out, mem_wdata, exp_v); end
  endtask

  task automatic test_priority();
    M_bus = 16'h0001; MMD = 1'b1; mem_rd_req = 1'b1; mem_wr_req = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL prio_load: got %h want %h", MDR_out, exp_v); end
    checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL prio_rd: got rd=%b wr=%b want 1/0", mem_rd, mem_wr); end
    // bus loads and new requests during the wait are ignored
    M_bus = 16'hFFFF; S_bus = 16'h0F0F; SMD = 1'b1; mem_wr_req = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    tick();
    MMD = 1'b0; SMD = 1'b0; mem_wr_req = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v || mem_rd !== 1'b1) begin errors++; $display("FAIL wait_hold: got mdr=%h rd=%b want %h/1", MDR_out, mem_rd, exp_v); end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    tick();
    mem_ack = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v || busy !== 1'b0) begin errors++; $display("FAIL prio_done: got mdr=%h busy=%b want %h/0", MDR_out, busy, exp_v); end
  endtask

  task automatic test_reset_abort();
    mem_rd_req = 1'b1;
    tick();
    mem_rd_req = 1'b0;
    tick();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    exp_q.push_back(16'h0000);
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (MDR_out !== exp_v) begin errors++; $display("FAIL abort_mdr: got %h want %h", MDR_out, exp_v); end
    checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b rd=%b err=%b want 0/0/0", busy, mem_rd, err); end
  endtask

  task automatic test_small_timeout();
    b_mem_rd_req = 1'b1;
    tick();
    b_mem_rd_req = 1'b0;
    b_mem_ack = 1'b1; b_mem_rdata = 8'h77;
    exp_q.push_back(16'h0077);
    tick();
    b_mem_ack = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if ({8'h00, b_MDR_out} !== exp_v) begin errors++; $display("FAIL b_rd_data: got %h want %h", b_MDR_out, exp_v); end
    checks++; if (b_busy !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL b_rd_done: got busy=%b err=%b want 0/0", b_busy, b_err); end
    b_mem_rd_req = 1'b1;
    tick();
    b_mem_rd_req = 1'b0;
    checks++; if (b_mem_rd !== 1'b1) begin errors++; $display("FAIL b_wait: got rd=%b want 1", b_mem_rd); end
    tick();
    checks++; if (b_err !== 1'b1 || b_mem_rd !== 1'b0) begin errors++; $display("FAIL b_err: got err=%b rd=%b want 1/0", b_err, b_mem_rd); end
    tick();
    checks++; if (b_err !== 1'b0 || b_busy !== 1'b0 || b_MDR_out !== 8'h77) begin errors++; $display("FAIL b_idle: got err=%b busy=%b mdr=%h want 0/0/77", b_err, b_busy, b_MDR_out); end
  endtask

  initial begin
    rst = 1'b1;
    M_bus = '0; S_bus = '0; MMD = 1'b0; SMD = 1'b0;
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    b_M_bus = '0; b_S_bus = '0; b_MMD = 1'b0; b_SMD = 1'b0;
    b_mem_rd_req = 1'b0; b_mem_wr_req = 1'b0; b_mem_rdata = '0; b_mem_ack = 1'b0;
    test_reset();
    test_bus_load();
    test_read();
    test_write_timeout();
    test_priority();
    test_reset_abort();
    test_small_timeout();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
